// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: pointer width, modular occupancy and output-buffer depth.
// Used by both the read and write controllers so their flag logic agrees.
package fifo_pkg;

  localparam int OBUF_DEPTH = 2;

  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  // Pointers carry a wrap bit, so the difference is taken modulo 2**pw.
  function automatic logic [31:0] ptr_occ(input logic [31:0] wp,
                                          input logic [31:0] rp,
                                          input int          pw);
    logic [31:0] mask;
    mask = (pw >= 32) ? '1 : ((32'd1 << pw) - 32'd1);
    return (wp - rp) & mask;
  endfunction

endpackage

// File: rtl/fifo_read_ctrl_fwft_if.sv
// Read-side FIFO bus: writer pointer/flush in, RAM read port, FWFT consumer port.
// Consumer handshake: a word transfers in any cycle where rd_valid and rd_req are both high.
interface fifo_read_ctrl_fwft_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  import fifo_pkg::*;

  logic [ptr_width(ADDR_WIDTH)-1:0] write_ptr;
  logic                             flush;
  logic                             rd_req;
  logic                             mem_rd_en;
  logic [ADDR_WIDTH-1:0]            mem_rd_addr;
  logic [DATA_WIDTH-1:0]            mem_rdata;
  logic [DATA_WIDTH-1:0]            rd_data;
  logic                             rd_valid;
  logic                             rd_ack;
  logic                             rd_underflow;
  logic [ptr_width(ADDR_WIDTH)-1:0] read_ptr;
  logic                             fifo_empty;
  logic                             fifo_aempty;
  logic [ADDR_WIDTH+1:0]            word_count;

  modport master (
    input  write_ptr, flush, rd_req, mem_rdata,
    output mem_rd_en, mem_rd_addr, rd_data, rd_valid, rd_ack, rd_underflow,
           read_ptr, fifo_empty, fifo_aempty, word_count
  );

  modport slave (
    output write_ptr, flush, rd_req, mem_rdata,
    input  mem_rd_en, mem_rd_addr, rd_data, rd_valid, rd_ack, rd_underflow,
           read_ptr, fifo_empty, fifo_aempty, word_count
  );

endinterface

// File: rtl/fwft_out_buf.sv
// Two-entry head/tail buffer holding words returned by the RAM until the consumer pops them.
module fwft_out_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  input  logic                  clr_i,
  output logic [DATA_WIDTH-1:0] head_data_o,
  output logic [1:0]            cnt_o
);

  logic [DATA_WIDTH-1:0] mem_q [OBUF_DEPTH];
  logic                  head_q, head_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  tail_idx;
  logic                  wr_en;
  logic                  pop_eff;

  always_comb begin
    pop_eff  = pop_i & (cnt_q != 2'd0);
    // With two slots the tail is the head, advanced once per stored word.
    tail_idx = head_q ^ cnt_q[0];
    wr_en    = push_i & ~clr_i;
    head_d   = head_q;
    cnt_d    = cnt_q;
    if (clr_i) begin
      head_d = 1'b0;
      cnt_d  = 2'd0;
    end else begin
      if (pop_eff) head_d = ~head_q;
      case ({push_i, pop_eff})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q <= 1'b0;
      cnt_q  <= 2'd0;
      for (int i = 0; i < OBUF_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q <= head_d;
      cnt_q  <= cnt_d;
      if (wr_en) mem_q[tail_idx] <= push_data_i;
    end
  end

  assign head_data_o = mem_q[head_q];
  assign cnt_o       = cnt_q;

endmodule

// File: rtl/fifo_read_ctrl_fwft.sv
// FIFO read controller: read pointer, empty/almost-empty flags, RAM read issue
// and a first-word-fall-through output stage fed by a 1-cycle-latency RAM.
module fifo_read_ctrl_fwft
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int AEMPTY     = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  fifo_read_ctrl_fwft_if.master  bus,
  output logic [1:0]             dbg_buf_cnt_o,
  output logic                   dbg_inflight_o
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam int CW = ADDR_WIDTH + 2;

  logic [PW-1:0]         read_ptr_q, read_ptr_d;
  logic                  inflight_q, inflight_d;
  logic                  rd_ack_q, rd_ack_d;
  logic                  rd_underflow_q, rd_underflow_d;

  logic [PW-1:0]         mem_occ;
  logic [PW-1:0]         ptr_inc;
  logic                  empty;
  logic                  aempty;
  logic                  rd_valid;
  logic                  pop;
  logic                  issue;
  logic                  push;
  logic [2:0]            pending;
  logic [1:0]            buf_cnt;
  logic [DATA_WIDTH-1:0] head_data;

  always_comb begin
    mem_occ  = PW'(ptr_occ(32'(bus.write_ptr), 32'(read_ptr_q), PW));
    empty    = (bus.write_ptr == read_ptr_q);
    aempty   = (32'(mem_occ) <= 32'(AEMPTY));
    rd_valid = (buf_cnt != 2'd0);
    pop      = bus.rd_req & rd_valid;
    // Words already buffered or on their way, after this cycle's pop leaves.
    pending  = 3'(buf_cnt) + 3'(inflight_q) - 3'(pop);
    issue    = ~empty & ~bus.flush & (pending < 3'd2);
    push     = inflight_q & ~bus.flush;

    if (32'(read_ptr_q[ADDR_WIDTH-1:0]) == 32'(DEPTH - 1)) begin
      ptr_inc = {~read_ptr_q[PW-1], {ADDR_WIDTH{1'b0}}};
    end else begin
      ptr_inc = {read_ptr_q[PW-1], read_ptr_q[ADDR_WIDTH-1:0] + 1'b1};
    end

    read_ptr_d     = read_ptr_q;
    inflight_d     = issue;
    rd_ack_d       = pop & ~bus.flush;
    rd_underflow_d = bus.rd_req & ~rd_valid & ~bus.flush;
    if (bus.flush) begin
      read_ptr_d = '0;
    end else if (issue) begin
      read_ptr_d = ptr_inc;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_ptr_q     <= '0;
      inflight_q     <= 1'b0;
      rd_ack_q       <= 1'b0;
      rd_underflow_q <= 1'b0;
    end else begin
      read_ptr_q     <= read_ptr_d;
      inflight_q     <= inflight_d;
      rd_ack_q       <= rd_ack_d;
      rd_underflow_q <= rd_underflow_d;
    end
  end

  fwft_out_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_buf (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (bus.mem_rdata),
    .pop_i       (pop),
    .clr_i       (bus.flush),
    .head_data_o (head_data),
    .cnt_o       (buf_cnt)
  );

  assign bus.mem_rd_en    = issue;
  assign bus.mem_rd_addr  = read_ptr_q[ADDR_WIDTH-1:0];
  assign bus.rd_data      = head_data;
  assign bus.rd_valid     = rd_valid;
  assign bus.rd_ack       = rd_ack_q;
  assign bus.rd_underflow = rd_underflow_q;
  assign bus.read_ptr     = read_ptr_q;
  assign bus.fifo_empty   = empty;
  assign bus.fifo_aempty  = aempty;
  assign bus.word_count   = CW'(mem_occ) + CW'(inflight_q) + CW'(buf_cnt);

  assign dbg_buf_cnt_o  = buf_cnt;
  assign dbg_inflight_o = inflight_q;

endmodule

// File: tb/tb_fifo_read_ctrl_fwft.sv
// Bench for fifo_read_ctrl_fwft: acts as write controller and 1-cycle RAM, checks FWFT reads.
module tb_fifo_read_ctrl_fwft;

  localparam int AW = 4;
  localparam int DW = 8;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] dbg_buf;
  logic       dbg_inf;

  always #5 clk = ~clk;

  fifo_read_ctrl_fwft_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fifo_read_ctrl_fwft #(
    .ADDR_WIDTH (AW),
    .DEPTH      (16),
    .DATA_WIDTH (DW),
    .AEMPTY     (3)
  ) u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .bus            (bus),
    .dbg_buf_cnt_o  (dbg_buf),
    .dbg_inflight_o (dbg_inf)
  );

  logic [DW-1:0] ram [16];
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= ram[bus.mem_rd_addr];

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [DW-1:0] exp_q[$];

  always @(negedge clk) begin
    if (reset_n === 1'b1 && (32'(dbg_buf) + 32'(dbg_inf) > 32'd2)) begin
      n_fail = n_fail + 1;
      $display("FAIL buf_bound: buf_cnt=%0d inflight=%0d exceeds 2", dbg_buf, dbg_inf);
    end
  end

  typedef struct {
    logic       req;
    logic [4:0] wp;
    logic       fl;
    logic       e_en;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_ack;
    logic       e_uf;
    logic [4:0] e_rp;
    logic       e_empty;
    logic       e_aempty;
    logic [5:0] e_wc;
    logic [1:0] e_buf;
    logic       e_inf;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive inputs just after the edge, sample once they settle.
  task automatic cyc(input logic req, input logic [4:0] wp, input logic fl);
    @(posedge clk);
    #1;
    bus.rd_req    = req;
    bus.write_ptr = wp;
    bus.flush     = fl;
    #1;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.rd_req    = 1'b0;
    bus.write_ptr = '0;
    bus.flush     = 1'b0;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // Holds rd_req high, scoreboarding every popped word.
  task automatic run_drain(input int ncyc, input logic [4:0] wp,
                           output int first, output int last,
                           output int npop, output int nack);
    first = -1; last = -1; npop = 0; nack = 0;
    for (int k = 0; k < ncyc; k++) begin
      cyc(1'b1, wp, 1'b0);
      if (bus.rd_ack) nack++;
      if (bus.rd_valid) begin
        if (first < 0) first = k;
        last = k;
        npop++;
        if (exp_q.size() == 0) begin
          n_tests = n_tests + 1;
          n_fail  = n_fail + 1;
          $display("FAIL extra_pop: cycle %0d data %0h with nothing expected", k, bus.rd_data);
        end else begin
          chk("pop_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
        end
      end
    end
  endtask

  int first, last, npop, nack, en_cnt;

  initial begin
    //            req  wp    fl  en  v  data   ack uf  rp    emp ae  wc    buf inf
    vecs[0] = '{1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 6'd0, 2'd0, 1'b0};
    vecs[1] = '{1'b0, 5'd1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 6'd1, 2'd0, 1'b0};
    vecs[2] = '{1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 6'd1, 2'd0, 1'b1};
    vecs[3] = '{1'b0, 5'd1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 6'd1, 2'd1, 1'b0};
    vecs[4] = '{1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 6'd1, 2'd1, 1'b0};
    vecs[5] = '{1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 1'b1, 1'b1, 6'd0, 2'd0, 1'b0};
    vecs[6] = '{1'b1, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 6'd0, 2'd0, 1'b0};
    vecs[7] = '{1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 1'b1, 1'b1, 6'd0, 2'd0, 1'b0};
    vecs[8] = '{1'b0, 5'd1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b1, 1'b1, 6'd0, 2'd0, 1'b0};
    vecs[9] = '{1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 6'd0, 2'd0, 1'b0};

    // Single word, underflow from reset, pop, flush.
    do_reset();
    ram[0] = 8'hA5;
    for (int i = 0; i < 10; i++) begin
      cyc(vecs[i].req, vecs[i].wp, vecs[i].fl);
      chk($sformatf("v%0d_en", i),    32'(bus.mem_rd_en),    32'(vecs[i].e_en));
      chk($sformatf("v%0d_valid", i), 32'(bus.rd_valid),     32'(vecs[i].e_valid));
      if (vecs[i].e_valid)
        chk($sformatf("v%0d_data", i), 32'(bus.rd_data),     32'(vecs[i].e_data));
      chk($sformatf("v%0d_ack", i),   32'(bus.rd_ack),       32'(vecs[i].e_ack));
      chk($sformatf("v%0d_uf", i),    32'(bus.rd_underflow), 32'(vecs[i].e_uf));
      chk($sformatf("v%0d_rp", i),    32'(bus.read_ptr),     32'(vecs[i].e_rp));
      chk($sformatf("v%0d_empty", i), 32'(bus.fifo_empty),   32'(vecs[i].e_empty));
      chk($sformatf("v%0d_aempty", i),32'(bus.fifo_aempty),  32'(vecs[i].e_aempty));
      chk($sformatf("v%0d_wc", i),    32'(bus.word_count),   32'(vecs[i].e_wc));
      chk($sformatf("v%0d_buf", i),   32'(dbg_buf),          32'(vecs[i].e_buf));
      chk($sformatf("v%0d_inf", i),   32'(dbg_inf),          32'(vecs[i].e_inf));
    end

    // 16-word burst with rd_req held high.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ram[i] = 8'(8'h10 + i);
      exp_q.push_back(8'(8'h10 + i));
    end
    run_drain(30, 5'b10000, first, last, npop, nack);
    chk("burst_first_pop", 32'(first), 32'd2);
    chk("burst_npop", 32'(npop), 32'd16);
    chk("burst_contiguous", 32'(last - first + 1), 32'd16);
    chk("burst_acks", 32'(nack), 32'd16);
    chk("burst_rp", 32'(bus.read_ptr), 32'h10);
    chk("burst_empty", 32'(bus.fifo_empty), 32'd1);

    // Almost-empty across the pointer wrap.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      ram[i] = 8'(8'h20 + i);
      exp_q.push_back(8'(8'h20 + i));
    end
    run_drain(20, 5'd12, first, last, npop, nack);
    chk("ae_pre_npop", 32'(npop), 32'd12);
    for (int i = 0; i < 5; i++) begin
      ram[(12 + i) % 16] = 8'(8'h60 + i);
      exp_q.push_back(8'(8'h60 + i));
    end
    cyc(1'b0, 5'b10001, 1'b0);
    chk("ae_c0_aempty", 32'(bus.fifo_aempty), 32'd0);
    chk("ae_c0_rp", 32'(bus.read_ptr), 32'd12);
    cyc(1'b0, 5'b10001, 1'b0);
    chk("ae_c1_aempty", 32'(bus.fifo_aempty), 32'd0);
    chk("ae_c1_rp", 32'(bus.read_ptr), 32'd13);
    cyc(1'b0, 5'b10001, 1'b0);
    chk("ae_c2_aempty", 32'(bus.fifo_aempty), 32'd1);
    chk("ae_c2_rp", 32'(bus.read_ptr), 32'b01110);
    chk("ae_c2_wc", 32'(bus.word_count), 32'd5);
    cyc(1'b1, 5'b10001, 1'b0);
    chk("ae_pop1_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
    cyc(1'b0, 5'b10001, 1'b0);
    chk("ae_pop1_rp", 32'(bus.read_ptr), 32'd15);
    chk("ae_pop1_aempty", 32'(bus.fifo_aempty), 32'd1);
    chk("ae_pop1_wc", 32'(bus.word_count), 32'd4);
    run_drain(12, 5'b10001, first, last, npop, nack);
    chk("ae_rest_npop", 32'(npop), 32'd4);
    chk("ae_final_rp", 32'(bus.read_ptr), 32'b10001);

    // Consumer stall with 10 words, then resume.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      ram[i] = 8'(8'h40 + i);
      exp_q.push_back(8'(8'h40 + i));
    end
    en_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b0, 5'd10, 1'b0);
      if (bus.mem_rd_en) en_cnt++;
    end
    chk("stall_en_cnt", 32'(en_cnt), 32'd2);
    chk("stall_buf", 32'(dbg_buf), 32'd2);
    chk("stall_inf", 32'(dbg_inf), 32'd0);
    chk("stall_wc", 32'(bus.word_count), 32'd10);
    chk("stall_rp", 32'(bus.read_ptr), 32'd2);
    run_drain(14, 5'd10, first, last, npop, nack);
    chk("resume_first", 32'(first), 32'd0);
    chk("resume_npop", 32'(npop), 32'd10);
    chk("resume_contiguous", 32'(last - first + 1), 32'd10);

    // Reset asserted mid-stream clears outputs immediately.
    do_reset();
    for (int k = 0; k < 4; k++) cyc(1'b0, 5'd10, 1'b0);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("mid_rst_rp", 32'(bus.read_ptr), 32'd0);
    chk("mid_rst_buf", 32'(dbg_buf), 32'd0);
    chk("mid_rst_wc", 32'(bus.word_count), 32'd10);

    // Flush the cycle after a read issue, with one word buffered.
    do_reset();
    ram[0] = 8'h77;
    ram[1] = 8'h88;
    cyc(1'b0, 5'd1, 1'b0);
    cyc(1'b0, 5'd1, 1'b0);
    cyc(1'b0, 5'd1, 1'b0);
    chk("fl_pre_data", 32'(bus.rd_data), 32'h77);
    cyc(1'b0, 5'd2, 1'b0);
    chk("fl_issue", 32'(bus.mem_rd_en), 32'd1);
    cyc(1'b0, 5'd2, 1'b1);
    chk("fl_en_forced", 32'(bus.mem_rd_en), 32'd0);
    chk("fl_buf_before", 32'(dbg_buf), 32'd1);
    chk("fl_inf_before", 32'(dbg_inf), 32'd1);
    cyc(1'b0, 5'd0, 1'b0);
    chk("fl_valid", 32'(bus.rd_valid), 32'd0);
    chk("fl_rp", 32'(bus.read_ptr), 32'd0);
    chk("fl_buf", 32'(dbg_buf), 32'd0);
    chk("fl_inf", 32'(dbg_inf), 32'd0);
    chk("fl_wc", 32'(bus.word_count), 32'd0);
    cyc(1'b0, 5'd0, 1'b0);
    chk("fl_late_valid", 32'(bus.rd_valid), 32'd0);
    chk("fl_late_buf", 32'(dbg_buf), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_read_ctrl_fwft.md
Name: fifo_read_ctrl_fwft

Overview:
- Read-side controller for the synchronous FIFO, the consumer-side counterpart to the FIFO write controller.
- Owns the read pointer and generates the empty and almost-empty flags from the write pointer.
- Issues reads to a 1-cycle-latency registered dual-port RAM.
- Presents data first-word-fall-through (FWFT) through a 2-entry output buffer, so the consumer sees a valid/ready-style interface at full throughput.

Parameters:
- ADDR_WIDTH, 4, RAM address bits; pointers are ADDR_WIDTH+1 bits (the MSB is the wrap bit).
- DEPTH, 16, RAM depth; must equal 2**ADDR_WIDTH.
- DATA_WIDTH, 8, word width.
- AEMPTY, 3, fifo_aempty asserts when RAM occupancy <= AEMPTY.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- write_ptr  in  ADDR_WIDTH+1  write pointer from the write controller (same clock).
- flush  in  1  synchronous clear; asserted in the same cycle as the writer's flush.
- rd_req  in  1  consumer pop request.
- mem_rd_en  out  1  RAM read strobe.
- mem_rd_addr  out  ADDR_WIDTH  RAM read address, equal to read_ptr[ADDR_WIDTH-1:0].
- mem_rdata  in  DATA_WIDTH  RAM output, valid the cycle after mem_rd_en.
- rd_data  out  DATA_WIDTH  head word of the output buffer.
- rd_valid  out  1  rd_data holds a valid word.
- rd_ack  out  1  registered pulse, high the cycle after an accepted pop.
- rd_underflow  out  1  registered pulse, high the cycle after rd_req arrives with rd_valid=0.
- read_ptr  out  ADDR_WIDTH+1  read pointer, fed back to the write controller.
- fifo_empty  out  1  RAM holds no unread words.
- fifo_aempty  out  1  RAM occupancy <= AEMPTY.
- word_count  out  ADDR_WIDTH+2  RAM occupancy + in-flight + buffered words.

Behaviour:
- Reset (async) values:
  - read_ptr=0, buf_cnt=0, inflight=0.
  - rd_valid=0, rd_ack=0, rd_underflow=0, rd_data=0.
  - Flags derive from pointers, so fifo_empty=1 whenever write_ptr=0.
- Pointer-derived signals:
  - mem_occ = write_ptr - read_ptr, computed modulo 2**(ADDR_WIDTH+1). Range 0..DEPTH.
  - fifo_empty = (write_ptr == read_ptr), full-width compare including the wrap bit.
  - fifo_aempty = (mem_occ <= AEMPTY). It is combinational.
- Pop rule:
  - pop = rd_req & rd_valid.
  - rd_req with rd_valid=0 is ignored: no state change, and rd_underflow pulses the next cycle.
- Issue rule: mem_rd_en = ~fifo_empty & ~flush & ((buf_cnt + inflight - pop) < 2).
  - On mem_rd_en, read_ptr increments by 1 at the next edge.
  - The wrap bit toggles when the low bits pass DEPTH-1.
- Pipeline bookkeeping:
  - inflight <= mem_rd_en.
  - When inflight=1, mem_rdata is written into the buffer tail that cycle.
- Output buffer: 2 entries, head/tail, buf_cnt in 0..2.
  - rd_valid = (buf_cnt != 0), and it is registered state.
  - Push and pop in the same cycle leaves buf_cnt unchanged, and data ordering is preserved.
- Latency:
  - With mem_rd_en high in cycle E, the word is visible on rd_data/rd_valid in cycle E+2.
  - A write completing at edge T raises mem_rd_en in cycle T (the first cycle with the updated write_ptr), so data appears at T+2.
- Throughput: sustained 1 word/cycle when rd_req is held high and the RAM stays non-empty.
- Buffer overflow is impossible by construction. Bench assertion: buf_cnt + inflight <= 2 at all times.
- flush, synchronous, takes priority over all else:
  - read_ptr<=0, buf_cnt<=0, inflight<=0, rd_valid<=0.
  - mem_rd_en is forced 0 in the flush cycle.
  - Any mem_rdata arriving in the cycle after flush is discarded.
  - rd_ack and rd_underflow are forced 0.
- Reset mid-stream: all in-flight and buffered data is lost; outputs return to reset values immediately.
- word_count = mem_occ + inflight + buf_cnt. Maximum value is DEPTH+2.

Decomposition:
- Shared package fifo_pkg holds:
  - the pointer-width function (ADDR_WIDTH+1);
  - the occupancy helper (modular pointer subtract);
  - the localparam OBUF_DEPTH=2.
  - These are reused by the write controller's flag logic.
- One sub-module: fwft_out_buf, the 2-entry buffer.
  - Inputs: push, push_data, pop, clr.
  - Outputs: head_data, cnt.
- The top level keeps the pointer, issue logic, flags and counters.

Test Plan:
- Reset, then write 1 word (write_ptr 0->1) with rd_req=0:
  - mem_rd_en pulses once; rd_valid=1 two cycles later; rd_data = word.
  - fifo_empty=1 and word_count=1 thereafter.
- Write 16 words, then hold rd_req=1:
  - 16 consecutive pops, one per cycle after the initial 2-cycle latency, data in order.
  - rd_ack is high 16 cycles; read_ptr ends at 5'b10000 (wrap bit set).
- AEMPTY=3, RAM holding 5 words, pop one at a time:
  - fifo_aempty rises exactly when mem_occ goes 4->3.
  - Confirms the modular compare across a pointer wrap (read_ptr 5'b01110, write_ptr 5'b10001).
- rd_req pulsed with rd_valid=0 from reset:
  - rd_underflow=1 the next cycle; read_ptr and buf_cnt unchanged.
- Consumer stalls (rd_req=0) with 10 words written:
  - mem_rd_en issues exactly twice, buf_cnt=2, inflight=0, word_count=10.
  - Resuming rd_req=1 yields all 10 words in order with no bubble.
- flush asserted in the cycle after mem_rd_en, with buf_cnt=1:
  - Next cycle rd_valid=0, read_ptr=0, buf_cnt=0; the late mem_rdata is discarded.
  - word_count=0 once write_ptr=0.
